// File: rtl/midi_pkg.sv
// midi_pkg: MIDI message types, status nibbles, FSM states and byte classification helpers
package midi_pkg;

   localparam logic [3:0] NOTE_OFF   = 4'h8;
   localparam logic [3:0] NOTE_ON    = 4'h9;
   localparam logic [3:0] POLY_AT    = 4'hA;
   localparam logic [3:0] CTRL_CHG   = 4'hB;
   localparam logic [3:0] PROG_CHG   = 4'hC;
   localparam logic [3:0] CHAN_AT    = 4'hD;
   localparam logic [3:0] PITCH_BEND = 4'hE;
   localparam logic [3:0] SYS        = 4'hF;

   typedef struct packed {
      logic [7:0] status;
      logic [7:0] data1;
      logic [7:0] data2;
   } midi_msg_t;

   typedef enum logic [2:0] {IDLE, GRANT, STATUS, DATA1, DATA2} state_e;

   function automatic logic [1:0] midi_msg_len(input logic [7:0] s);
      if (!s[7]) return 2'd0;
      case (s[7:4])
         NOTE_OFF, NOTE_ON, POLY_AT, CTRL_CHG, PITCH_BEND: return 2'd3;
         PROG_CHG, CHAN_AT: return 2'd2;
         SYS: return s[3:0] == 4'h2 ? 2'd3 :
                     (s[3:0] == 4'h1 || s[3:0] == 4'h3) ? 2'd2 :
                     s[3:0] == 4'h6 ? 2'd1 : 2'd0;
         default: return 2'd0;
      endcase
   endfunction

   function automatic logic is_realtime(input logic [7:0] b);
      return b >= 8'hF8;
   endfunction

   function automatic logic is_channel(input logic [7:0] s);
      return s[7] && s[7:4] != SYS;
   endfunction

endpackage

// File: rtl/midi_rr_arbiter.sv
// midi_rr_arbiter: picks the first set request after the pointer, wrapping around
module midi_rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req_i,
   input  logic [$clog2(NREQ)-1:0] ptr_i,
   output logic [$clog2(NREQ)-1:0] gnt_o,
   output logic                    any_o
);
   localparam int GW = $clog2(NREQ);

   logic [GW-1:0] idx;

   always_comb begin
      gnt_o = '0;
      any_o = 1'b0;
      idx   = '0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = GW'((int'(ptr_i) + k) % NREQ);
         if (req_i[idx]) begin
            gnt_o = idx;
            any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/midi_tx_sched.sv
// midi_tx_sched: round-robin MIDI message scheduler onto one byte transmitter,
// with running status and top-priority real-time byte injection
module midi_tx_sched
   import midi_pkg::*;
#(
   parameter int NREQ           = 4,
   parameter bit RUNNING_STATUS = 1'b1,
   parameter int RS_TIMEOUT_CYC = 30_000_000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid_i,
   input  logic [NREQ*24-1:0]      req_msg_i,
   output logic [NREQ-1:0]         req_ready_o,
   input  logic                    rt_valid_i,
   input  logic [7:0]              rt_byte_i,
   output logic                    rt_ready_o,
   output logic [7:0]              tx_data_o,
   output logic                    tx_valid_o,
   input  logic                    tx_ready_i,
   output logic                    busy_o,
   output logic [$clog2(NREQ)-1:0] grant_id_o,
   output logic                    err_drop_o
);
   localparam int GW = $clog2(NREQ);
   localparam int CW = $clog2(RS_TIMEOUT_CYC + 1);

   state_e          state_q;
   midi_msg_t       msg_q;
   logic [1:0]      len_q;
   logic            loaded_q;
   logic [GW-1:0]   ptr_q, gid_q;
   logic [7:0]      rs_q;
   logic [CW-1:0]   cnt_q;
   logic [7:0]      tx_data_q;
   logic            tx_valid_q;
   logic [NREQ-1:0] req_ready_q;
   logic            rt_ready_q, busy_q, err_q;

   midi_msg_t       msgs [NREQ];
   midi_msg_t       m_in;
   logic [1:0]      len_in;
   logic [GW-1:0]   gnt;
   logic            any;
   logic            acc, msg_acc, rt_take, rt_drop, rt_load;
   logic            in_msg, skip_now, msg_load, last, rs_expired;
   logic [7:0]      cur_byte;

   for (genvar g = 0; g < NREQ; g++) begin : g_msg
      assign msgs[g] = req_msg_i[24*g +: 24];
   end

   midi_rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req_i (req_valid_i),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .any_o (any)
   );

   always_comb begin
      m_in       = msgs[gid_q];
      len_in     = midi_msg_len(m_in.status);
      acc        = tx_valid_q && tx_ready_i;
      msg_acc    = acc && loaded_q;
      rt_take    = rt_valid_i && !tx_valid_q && !rt_ready_q;
      rt_drop    = rt_take && !is_realtime(rt_byte_i);
      rt_load    = rt_take && !rt_drop;
      in_msg     = state_q == STATUS || state_q == DATA1 || state_q == DATA2;
      skip_now   = RUNNING_STATUS && state_q == STATUS && !loaded_q &&
                   is_channel(msg_q.status) && msg_q.status == rs_q;
      msg_load   = in_msg && !loaded_q && !tx_valid_q && !rt_take && !skip_now;
      cur_byte   = state_q == STATUS ? msg_q.status : state_q == DATA1 ? msg_q.data1 : msg_q.data2;
      last       = state_q == DATA2 || (state_q == DATA1 && len_q == 2'd2) ||
                   (state_q == STATUS && len_q == 2'd1);
      rs_expired = cnt_q == CW'(RS_TIMEOUT_CYC);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         msg_q       <= '0;
         len_q       <= '0;
         loaded_q    <= 1'b0;
         ptr_q       <= GW'(NREQ - 1);
         gid_q       <= '0;
         rs_q        <= '0;
         cnt_q       <= '0;
         tx_data_q   <= '0;
         tx_valid_q  <= 1'b0;
         req_ready_q <= '0;
         rt_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         req_ready_q <= '0;
         rt_ready_q  <= rt_take;
         err_q       <= rt_drop;
         cnt_q       <= msg_acc ? '0 : rs_expired ? cnt_q : cnt_q + 1'b1;
         if (rt_load) begin
            tx_data_q  <= rt_byte_i;
            tx_valid_q <= 1'b1;
         end else if (msg_load) begin
            tx_data_q  <= cur_byte;
            tx_valid_q <= 1'b1;
         end else if (acc) begin
            tx_valid_q <= 1'b0;
         end
         if (msg_load) loaded_q <= 1'b1;
         else if (msg_acc) loaded_q <= 1'b0;
         // a status byte being sent takes precedence over the idle timeout
         if (msg_load && state_q == STATUS) rs_q <= is_channel(msg_q.status) ? msg_q.status : 8'h00;
         else if (rs_expired && !msg_acc) rs_q <= 8'h00;
         case (state_q)
            IDLE: if (any) begin
               gid_q       <= gnt;
               req_ready_q <= NREQ'(1) << gnt;
               state_q     <= GRANT;
            end
            GRANT: if (req_valid_i[gid_q]) begin
               ptr_q   <= gid_q;
               msg_q   <= '{status: m_in.status, data1: m_in.data1 & 8'h7F, data2: m_in.data2 & 8'h7F};
               len_q   <= len_in;
               busy_q  <= len_in != 2'd0;
               state_q <= len_in == 2'd0 ? IDLE : STATUS;
               if (len_in == 2'd0) err_q <= 1'b1;
            end else begin
               state_q <= IDLE;
            end
            default: if (skip_now) begin
               state_q <= DATA1;
            end else if (msg_acc) begin
               state_q <= last ? IDLE : state_q == STATUS ? DATA1 : DATA2;
               busy_q  <= !last;
            end
         endcase
      end
   end

   assign req_ready_o = req_ready_q;
   assign rt_ready_o  = rt_ready_q;
   assign tx_data_o   = tx_data_q;
   assign tx_valid_o  = tx_valid_q;
   assign busy_o      = busy_q;
   assign grant_id_o  = gid_q;
   assign err_drop_o  = err_q;

endmodule

// File: tb/tb_midi_tx_sched.sv
// tb_midi_tx_sched: directed scoreboard bench for the MIDI transmit scheduler
module tb_midi_tx_sched;
   localparam int NREQ = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ*24-1:0] req_msg = '0;
   logic [NREQ-1:0]   req_ready;
   logic              rt_valid = 1'b0;
   logic [7:0]        rt_byte = 8'h00;
   logic              rt_ready;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready = 1'b1;
   logic              busy;
   logic [1:0]        grant_id;
   logic              err_drop;

   int n_tests = 0, n_fail = 0, n_rdy = 0, n_rt = 0, n_err = 0;
   logic [7:0]  exp_q [$];
   int          exp_g [$];
   logic [23:0] pend [NREQ][$];

   always #5 clk = ~clk;

   midi_tx_sched #(.NREQ(NREQ), .RUNNING_STATUS(1'b1), .RS_TIMEOUT_CYC(50)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid),
      .req_msg_i   (req_msg),
      .req_ready_o (req_ready),
      .rt_valid_i  (rt_valid),
      .rt_byte_i   (rt_byte),
      .rt_ready_o  (rt_ready),
      .tx_data_o   (tx_data),
      .tx_valid_o  (tx_valid),
      .tx_ready_i  (tx_ready),
      .busy_o      (busy),
      .grant_id_o  (grant_id),
      .err_drop_o  (err_drop)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input int i, input logic [23:0] m);
      pend[i].push_back(m);
   endtask

   task automatic expb(input logic [7:0] b);
      exp_q.push_back(b);
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i] = pend[i].size() != 0;
         if (pend[i].size() != 0) req_msg[24*i +: 24] = pend[i][0];
         else req_msg[24*i +: 24] = 24'h0;
      end
   endtask

   task automatic step();
      logic [NREQ-1:0] rdy;
      logic            rtr;
      @(negedge clk);
      rdy = req_ready;
      rtr = rt_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++)
         if (rdy[i] && pend[i].size() != 0) void'(pend[i].pop_front());
      if (rtr) rt_valid = 1'b0;
      drive();
   endtask

   function automatic bit pending();
      bit p = busy || tx_valid || rt_valid || exp_q.size() != 0 || exp_g.size() != 0;
      for (int i = 0; i < NREQ; i++) p |= pend[i].size() != 0;
      return p;
   endfunction

   task automatic drain(input string tag);
      int n = 0;
      drive();
      while (pending() && n < 200) begin
         step();
         n++;
      end
      repeat (3) step();
      check({tag, "_drain"}, exp_q.size() + exp_g.size(), 0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      for (int i = 0; i < NREQ; i++) pend[i].delete();
      rt_valid = 1'b0;
      drive();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   // scoreboard side: pops expectations whenever the DUT moves a byte or grants
   initial forever begin
      logic [7:0] e;
      int         g;
      @(negedge clk);
      if (rst) begin
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $error("FAIL tx_extra: observed %0h expected none", tx_data);
            end else begin
               e = exp_q.pop_front();
               check("tx_byte", tx_data, e);
               if (e < 8'hF8) check("busy_msg", busy, 1);
            end
         end
         if (req_ready != '0) begin
            n_rdy++;
            if (exp_g.size() == 0) begin
               n_tests++;
               n_fail++;
               $error("FAIL grant_extra: observed %0h expected none", req_ready);
            end else begin
               g = exp_g.pop_front();
               check("req_ready", req_ready, 32'(1) << g);
               check("grant_id", grant_id, g);
            end
         end
         if (rt_ready) n_rt++;
         if (err_drop) n_err++;
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ord [6] = '{0, 1, 2, 3, 0, 1};
      int n, c0, r0, e0;
      logic [7:0] s, d1, d2;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_busy", busy, 0);
      check("rst_grant_id", grant_id, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_rt_ready", rt_ready, 0);
      check("rst_err_drop", err_drop, 0);
      @(posedge clk);
      #1 rst = 1'b1;

      c0 = n_rdy;
      send(0, 24'h903C64);
      expb(8'h90); expb(8'h3C); expb(8'h64); exp_g.push_back(0);
      drain("t1");
      check("t1_rdy_cnt", n_rdy - c0, 1);
      check("t1_gid", grant_id, 0);

      do_reset();
      send(0, 24'hB02E7F);
      send(1, 24'hB02F7F);
      expb(8'hB0); expb(8'h2E); expb(8'h7F); expb(8'h2F); expb(8'h7F);
      exp_g.push_back(0); exp_g.push_back(1);
      drain("t2");

      do_reset();
      c0 = n_rdy;
      for (int i = 0; i < NREQ; i++) send(i, {8'hB0 + 8'(i), 8'h20 + 8'(i), 8'h01});
      send(0, 24'hB02002);
      send(1, 24'hB12102);
      for (int k = 0; k < 6; k++) begin
         s  = 8'hB0 + 8'(ord[k]);
         d1 = 8'h20 + 8'(ord[k]);
         d2 = k >= 4 ? 8'h02 : 8'h01;
         expb(s); expb(d1); expb(d2);
         exp_g.push_back(ord[k]);
      end
      drain("t3");
      check("t3_rdy_cnt", n_rdy - c0, 6);

      send(0, 24'hC00500);
      expb(8'hC0); expb(8'h05); exp_g.push_back(0);
      drain("t4a");
      repeat (60) step();
      send(0, 24'hC00600);
      expb(8'hC0); expb(8'h06); exp_g.push_back(0);
      drain("t4b");
      repeat (10) step();
      send(0, 24'hC00700);
      expb(8'h07); exp_g.push_back(0);
      drain("t4c");

      tx_ready = 1'b0;
      r0 = n_rt;
      send(0, 24'h903C64);
      expb(8'h90); expb(8'hF8); expb(8'h3C); expb(8'h64); exp_g.push_back(0);
      drive();
      n = 0;
      while (!tx_valid && n < 20) begin
         step();
         n++;
      end
      rt_byte  = 8'hF8;
      rt_valid = 1'b1;
      repeat (3) step();
      check("t5_hold", tx_data, 8'h90);
      check("t5_rt_wait", n_rt - r0, 0);
      tx_ready = 1'b1;
      drain("t5a");
      check("t5_rt_cnt", n_rt - r0, 1);
      send(0, 24'h903E64);
      expb(8'h3E); expb(8'h64); exp_g.push_back(0);
      drain("t5b");

      e0 = n_err;
      send(0, 24'h3C4000);
      exp_g.push_back(0);
      drain("t6_msg_drop");
      check("t6_msg_err", n_err - e0, 1);

      e0 = n_err;
      r0 = n_rt;
      rt_byte  = 8'hF0;
      rt_valid = 1'b1;
      drain("t6_rt_drop");
      check("t6_rt_err", n_err - e0, 1);
      check("t6_rt_cnt", n_rt - r0, 1);

      do_reset();
      send(0, 24'h903C64);
      expb(8'h90); exp_g.push_back(0);
      drive();
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         step();
         n++;
      end
      check("t7_sent90", exp_q.size(), 0);
      rst = 1'b0;
      for (int i = 0; i < NREQ; i++) pend[i].delete();
      drive();
      @(negedge clk);
      check("t7_tx_valid", tx_valid, 0);
      check("t7_busy", busy, 0);
      check("t7_req_ready", req_ready, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      send(0, 24'h903C64);
      expb(8'h90); expb(8'h3C); expb(8'h64); exp_g.push_back(0);
      drain("t7");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
